// File: rtl/mul_arb.sv
// Two-requester arbiter in front of one shared 4x4 shift-and-add multiplier.
// Each product takes one IDLE handshake cycle, four CALC cycles and a RESP handshake.
module mul_arb #(
    parameter int PRIO_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    input  logic       rsp_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t     state;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_id;
    logic [7:0] acc;
    logic [1:0] cnt;
    logic       last_grant;

    logic       grant1;
    logic       accept;
    logic [7:0] addend;
    logic [7:0] acc_next;

    // Requester 1 wins when alone, or on a tie in round-robin mode when requester 0 went last.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || (PRIO_MODE == 0 && !last_grant));
    end

    // Ready is gated by rst so nothing looks acceptable while reset is held.
    assign req0_ready = rst && (state == IDLE) && req0_valid && !grant1;
    assign req1_ready = rst && (state == IDLE) && req1_valid && grant1;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        addend   = op_b[cnt] ? ({4'b0000, op_a} << cnt) : 8'd0;
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op_a       <= 4'd0;
            op_b       <= 4'd0;
            op_id      <= 1'b0;
            acc        <= 8'd0;
            cnt        <= 2'd0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_p      <= 8'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant1 ? req1_a : req0_a;
                        op_b       <= grant1 ? req1_b : req0_b;
                        op_id      <= grant1;
                        last_grant <= grant1;
                        acc        <= 8'd0;
                        cnt        <= 2'd0;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 2'd1;
                    // The final partial product goes straight into the response register.
                    if (cnt == 2'd3) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_p     <= acc_next;
                        rsp_id    <= op_id;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arb.sv
// Bench for mul_arb: a round-robin instance with a scoreboard monitor, plus a
// fixed-priority instance used for the arbitration ordering scenario.
module tb_mul_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, busy;
    logic [7:0] rsp_p;
    logic       rsp_ready = 1'b0;

    logic       fp_req0_valid = 1'b0, fp_req1_valid = 1'b0;
    logic [3:0] fp_req0_a = 4'd0, fp_req0_b = 4'd0, fp_req1_a = 4'd0, fp_req1_b = 4'd0;
    logic       fp_req0_ready, fp_req1_ready;
    logic       fp_rsp_valid, fp_rsp_id, fp_busy;
    logic [7:0] fp_rsp_p;
    logic       fp_rsp_ready = 1'b0;

    typedef struct {
        logic       id;
        logic [7:0] p;
        int         hs_edge;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    exp_t pushed;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    mul_arb #(.PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    mul_arb #(.PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(fp_req0_valid), .req0_a(fp_req0_a), .req0_b(fp_req0_b), .req0_ready(fp_req0_ready),
        .req1_valid(fp_req1_valid), .req1_a(fp_req1_a), .req1_b(fp_req1_b), .req1_ready(fp_req1_ready),
        .rsp_valid(fp_rsp_valid), .rsp_id(fp_rsp_id), .rsp_p(fp_rsp_p), .rsp_ready(fp_rsp_ready),
        .busy(fp_busy)
    );

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        return {4'b0000, a} * {4'b0000, b};
    endfunction

    always @(posedge clk) cyc++;

    // An aborted operation must never produce a response.
    always @(negedge rst) sb.delete();

    // Scoreboard: push on a pending handshake, check latency on rsp_valid rise, pop on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid) begin
                checks++;
                if (sb.size() == 0)
                    $display("[TB] FAIL rsp_latency: got unexpected rsp_valid, required no response");
                else if ((cyc - sb[0].hs_edge) !== 4)
                    $display("[TB] FAIL rsp_latency: got %0d edges, required 4", cyc - sb[0].hs_edge);
                else
                    passes++;
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL rsp_data: got id=%0d p=%0d, required no response", rsp_id, rsp_p);
                end else begin
                    popped = sb.pop_front();
                    if ({rsp_id, rsp_p} !== {popped.id, popped.p})
                        $display("[TB] FAIL rsp_data: got id=%0d p=%0d, required id=%0d p=%0d",
                                 rsp_id, rsp_p, popped.id, popped.p);
                    else
                        passes++;
                end
            end
            prev_valid = rsp_valid;
            if (req0_valid && req0_ready) begin
                pushed.id = 1'b0; pushed.p = prod(req0_a, req0_b); pushed.hs_edge = cyc + 1;
                sb.push_back(pushed);
            end
            if (req1_valid && req1_ready) begin
                pushed.id = 1'b1; pushed.p = prod(req1_a, req1_b); pushed.hs_edge = cyc + 1;
                sb.push_back(pushed);
            end
        end
    end

    task automatic send(input logic id, input logic [3:0] a, input logic [3:0] b);
        int   n;
        logic got;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            n++;
        end
        checks++;
        if (!got) $display("[TB] FAIL send_handshake: id=%0d got ready=0 after %0d cycles, required 1", id, n);
        else passes++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || rsp_valid) $display("[TB] FAIL wait_idle: got busy=%0d rsp_valid=%0d, required 0/0", busy, rsp_valid);
        else passes++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            req0_valid = 1'($urandom_range(0, 1)); req0_a = 4'($urandom); req0_b = 4'($urandom);
            req1_valid = 1'($urandom_range(0, 1)); req1_a = 4'($urandom); req1_b = 4'($urandom);
            rsp_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy} !== 13'h0)
                $display("[TB] FAIL reset_outputs: got %h, required 0",
                         {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy});
            else passes++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single;
        int n;
        @(posedge clk); #1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd7;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b100)
            $display("[TB] FAIL single_ready: got %b, required 100", {req0_ready, req1_ready, busy});
        else passes++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 4) $display("[TB] FAIL single_latency: got %0d edges, required 4", n);
        else passes++;
        checks++;
        if ({rsp_valid, rsp_id, rsp_p} !== {1'b1, 1'b0, 8'd14})
            $display("[TB] FAIL single_result: got v=%0d id=%0d p=%0d, required v=1 id=0 p=14", rsp_valid, rsp_id, rsp_p);
        else passes++;
        wait_idle();
    endtask

    task automatic test_corners;
        logic [3:0] ta[5];
        logic [3:0] tb[5];
        ta = '{4'd15, 4'd15, 4'd0, 4'd9, 4'd1};
        tb = '{4'd3,  4'd15, 4'd9, 4'd0, 4'd1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, ta[i], tb[i]);
            wait_idle();
        end
        for (int i = 0; i < 4; i++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            wait_idle();
        end
    endtask

    task automatic test_arbitration;
        int         rr_ord[$];
        int         fp_ord[$];
        int         rr_cyc[$];
        int         n;
        logic [7:0] fexp;
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b1; fp_rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd7;
        fp_req0_valid = 1'b1; fp_req0_a = 4'd3; fp_req0_b = 4'd5;
        fp_req1_valid = 1'b1; fp_req1_a = 4'd6; fp_req1_b = 4'd7;
        n = 0;
        while ((rr_ord.size() < 4 || fp_ord.size() < 4) && n < 100) begin
            @(negedge clk);
            n++;
            if (rr_ord.size() < 4) begin
                if (req0_ready) begin rr_ord.push_back(0); rr_cyc.push_back(cyc); end
                else if (req1_ready) begin rr_ord.push_back(1); rr_cyc.push_back(cyc); end
            end
            if (fp_ord.size() < 4) begin
                if (fp_req0_ready) fp_ord.push_back(0);
                else if (fp_req1_ready) fp_ord.push_back(1);
            end
            if (fp_rsp_valid && fp_rsp_ready) begin
                fexp = fp_rsp_id ? 8'd42 : 8'd15;
                checks++;
                if (fp_rsp_p !== fexp) $display("[TB] FAIL fp_result: got %0d, required %0d", fp_rsp_p, fexp);
                else passes++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
        checks++;
        if (rr_ord.size() !== 4 || fp_ord.size() !== 4)
            $display("[TB] FAIL grant_count: got rr=%0d fp=%0d, required 4/4", rr_ord.size(), fp_ord.size());
        else passes++;
        for (int i = 0; i < rr_ord.size(); i++) begin
            checks++;
            if (rr_ord[i] !== (i % 2)) $display("[TB] FAIL rr_grant[%0d]: got %0d, required %0d", i, rr_ord[i], i % 2);
            else passes++;
        end
        for (int i = 0; i < fp_ord.size(); i++) begin
            checks++;
            if (fp_ord[i] !== 0) $display("[TB] FAIL fp_grant[%0d]: got %0d, required 0", i, fp_ord[i]);
            else passes++;
        end
        for (int i = 1; i < rr_cyc.size(); i++) begin
            checks++;
            if ((rr_cyc[i] - rr_cyc[i-1]) !== 6)
                $display("[TB] FAIL back_to_back[%0d]: got %0d cycles, required 6", i, rr_cyc[i] - rr_cyc[i-1]);
            else passes++;
        end
        wait_idle();
        n = 0;
        while (fp_busy && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (fp_busy) $display("[TB] FAIL fp_idle: got busy=1, required 0");
        else passes++;
    endtask

    task automatic test_backpressure;
        int n;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(1'b0, 4'd9, 4'd9);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!rsp_valid) $display("[TB] FAIL bp_valid: got rsp_valid=0, required 1");
        else passes++;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_p, req0_ready, req1_ready, busy} !== {1'b1, 1'b0, 8'd81, 1'b0, 1'b0, 1'b1})
                $display("[TB] FAIL bp_hold: got v=%0d id=%0d p=%0d r0=%0d r1=%0d busy=%0d, required 1/0/81/0/0/1",
                         rsp_valid, rsp_id, rsp_p, req0_ready, req1_ready, busy);
            else passes++;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, rsp_valid, rsp_p} !== {1'b0, 1'b0, 8'd81})
            $display("[TB] FAIL bp_release: got busy=%0d v=%0d p=%0d, required 0/0/81", busy, rsp_valid, rsp_p);
        else passes++;
    endtask

    task automatic test_reset_abort;
        int bad;
        rsp_ready = 1'b1;
        send(1'b1, 4'd15, 4'd15);
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy} !== 13'h0)
            $display("[TB] FAIL abort_clear: got %h, required 0", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy});
        else passes++;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        checks++;
        if (bad !== 0) $display("[TB] FAIL abort_no_rsp: got %0d valid cycles, required 0", bad);
        else passes++;
        send(1'b0, 4'd2, 4'd7);
        wait_idle();
        checks++;
        if (sb.size() !== 0) $display("[TB] FAIL sb_drained: got %0d pending, required 0", sb.size());
        else passes++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_arbitration();
        test_backpressure();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
